// File: rtl/bus_wait_gen.sv
// bus_wait_gen: per-device wait-state generator for the 6502 bus.
// Holds RDY low for RAM_WAIT/ROM_WAIT clocks after each cycle_start.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   cycle_start  1-clk pulse, new CPU bus cycle with valid address
//   ram_cs       RAM chip select from the address decoder
//   rom_cs       ROM chip select from the address decoder
//   rdy          CPU RDY, 0 stalls the current bus cycle
//   access_done  1-clk pulse when the selected access completes
//   sel          device latched at cycle_start: 00 none, 01 RAM, 10 ROM
//   cs_err       sticky decode fault flag, cleared only by rst
module bus_wait_gen #(
  parameter int RAM_WAIT = 0,
  parameter int ROM_WAIT = 3,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cycle_start,
  input  logic       ram_cs,
  input  logic       rom_cs,
  output logic       rdy,
  output logic       access_done,
  output logic [1:0] sel,
  output logic       cs_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] RAM_N = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] ROM_N = CNT_W'(ROM_WAIT);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_wait;
  logic [1:0]       sel_next;
  logic             dec_fault;

  // ROM wins when both selects are active, so a
  // priority decode is needed here.
  always_comb begin
    n_wait = '0;
    priority case (1'b1)
      rom_cs:  n_wait = ROM_N;
      ram_cs:  n_wait = RAM_N;
      default: n_wait = '0;
    endcase
  end

  assign sel_next  = {rom_cs, ram_cs & ~rom_cs};
  assign dec_fault = ~(rom_cs ^ ram_cs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rdy         <= 1'b1;
      access_done <= 1'b0;
      sel         <= 2'b00;
      cs_err      <= 1'b0;
    end else begin
      case (state)
        // DONE accepts a new cycle exactly like IDLE,
        // giving back-to-back accesses with no gap.
        S_IDLE, S_DONE: begin
          if (cycle_start) begin
            sel <= sel_next;
            if (dec_fault)
              cs_err <= 1'b1;
            if (n_wait != '0) begin
              rdy         <= 1'b0;
              cnt         <= n_wait - 1'b1;
              access_done <= 1'b0;
              state       <= S_WAIT;
            end else begin
              rdy         <= 1'b1;
              access_done <= 1'b1;
              state       <= S_DONE;
            end
          end else begin
            access_done <= 1'b0;
            state       <= S_IDLE;
          end
        end
        S_WAIT: begin
          // CPU is stalled, so a new cycle here
          // can only be a protocol fault.
          if (cycle_start)
            cs_err <= 1'b1;
          if (cnt == '0) begin
            rdy         <= 1'b1;
            access_done <= 1'b1;
            state       <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          rdy         <= 1'b1;
          access_done <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
